// File: rtl/thermo_pkg.sv
// rtl/thermo_pkg.sv - thermostat controller state encodings and default constants
package thermo_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        HEAT    = 2'b01,
        COOL    = 2'b10,
        LOCKOUT = 2'b11
    } thermo_state_t;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_DEADBAND = 4;
    localparam int DEF_MIN_ON   = 16;
    localparam int DEF_MIN_OFF  = 8;
    localparam int DEF_CNT_W    = 8;
    localparam int DEF_MAX_RUN  = 64;

endpackage

// File: rtl/thermo_timer.sv
// rtl/thermo_timer.sv - loadable down-counter that saturates at zero
module thermo_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/thermo_ctrl_fsm.sv
// rtl/thermo_ctrl_fsm.sv - thermostat FSM with deadband, min run and lockout; THERMO_ALARM_EN adds run-length fault
module thermo_ctrl_fsm
    import thermo_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEADBAND = DEF_DEADBAND,
    parameter int MIN_ON   = DEF_MIN_ON,
    parameter int MIN_OFF  = DEF_MIN_OFF,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int MAX_RUN  = DEF_MAX_RUN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] Tset,
    input  logic [WIDTH-1:0] Tact,
    input  logic             clr_fault,
    output logic             heat_on,
    output logic             cool_on,
    output logic [1:0]       state,
    output logic             fault
);

    localparam logic signed [WIDTH:0] DB      = $signed((WIDTH+1)'(DEADBAND));
    localparam logic [CNT_W-1:0]      ON_LOAD  = CNT_W'(MIN_ON - 1);
    localparam logic [CNT_W-1:0]      OFF_LOAD = CNT_W'(MIN_OFF - 1);

    thermo_state_t state_q, state_d;

    logic signed [WIDTH:0] diff;
    logic                  too_cold, too_hot;
    logic                  tmr_load, tmr_dec, tmr_zero;
    logic [CNT_W-1:0]      tmr_val;
    logic                  start_run;
    logic                  alarm_hit;
    logic                  run_block;

    // Extended by one bit so a large Tact never wraps into "too cold".
    assign diff     = $signed({1'b0, Tset}) - $signed({1'b0, Tact});
    assign too_cold = (diff >= DB);
    assign too_hot  = ((-diff) >= DB);

    thermo_timer #(.CNT_W(CNT_W)) u_run_tmr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d   = state_q;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        tmr_dec   = (state_q != IDLE);
        start_run = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && !run_block && too_cold) begin
                    state_d   = HEAT;
                    tmr_load  = 1'b1;
                    tmr_val   = ON_LOAD;
                    start_run = 1'b1;
                end else if (en && !run_block && too_hot) begin
                    state_d   = COOL;
                    tmr_load  = 1'b1;
                    tmr_val   = ON_LOAD;
                    start_run = 1'b1;
                end
            end
            HEAT: begin
                if ((tmr_zero && ((Tact >= Tset) || !en)) || alarm_hit) begin
                    state_d  = LOCKOUT;
                    tmr_load = 1'b1;
                    tmr_val  = OFF_LOAD;
                end
            end
            COOL: begin
                if ((tmr_zero && ((Tact <= Tset) || !en)) || alarm_hit) begin
                    state_d  = LOCKOUT;
                    tmr_load = 1'b1;
                    tmr_val  = OFF_LOAD;
                end
            end
            LOCKOUT: begin
                if (tmr_zero) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign heat_on = (state_q == HEAT);
    assign cool_on = (state_q == COOL);
    assign state   = state_q;

`ifdef THERMO_ALARM_EN
    logic in_run, run_cnt_zero;
    logic fault_q, fault_d;

    assign in_run = (state_q == HEAT) || (state_q == COOL);

    // Counts run cycles down from MAX_RUN-1; zero in a run marks the MAX_RUN-th cycle.
    thermo_timer #(.CNT_W(CNT_W)) u_run_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (start_run),
        .load_val (CNT_W'(MAX_RUN - 1)),
        .dec      (in_run),
        .zero     (run_cnt_zero)
    );

    assign alarm_hit = in_run && run_cnt_zero;

    always_comb begin
        fault_d = fault_q;
        if (clr_fault) begin
            fault_d = 1'b0;
        end
        if (alarm_hit) begin
            fault_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign fault     = fault_q;
    assign run_block = fault_q;
`else
    logic unused_alarm;

    assign alarm_hit    = 1'b0;
    assign run_block    = 1'b0;
    assign fault        = 1'b0;
    assign unused_alarm = ^{clr_fault, start_run, (MAX_RUN != 0)};
`endif

endmodule

// File: doc/thermo_ctrl_fsm.md
Name: thermo_ctrl_fsm

Overview:
- Sequential thermostat controller.
- Decides heater/cooler drive from setpoint and actual temperature, using a deadband for hysteresis.
- Enforces a minimum run time and a post-run lockout (compressor/element protection).
- Sits between the temperature sample registers and the HVAC drive outputs; replaces purely combinational Hon/Con generation.

Parameters:
- WIDTH, 8: temperature word width (unsigned)
- DEADBAND, 4: |Tset-Tact| threshold to start heating/cooling
- MIN_ON, 16: minimum cycles in HEAT or COOL
- MIN_OFF, 8: cycles in LOCKOUT after any run
- CNT_W, 8: timer width; must hold max(MIN_ON, MIN_OFF, MAX_RUN)
- MAX_RUN, 64: run-length fault limit (used only with THERMO_ALARM_EN)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  controller enable
- Tset  in  WIDTH  setpoint, unsigned
- Tact  in  WIDTH  measured temperature, unsigned
- clr_fault  in  1  clears sticky fault (THERMO_ALARM_EN only)
- heat_on  out  1  heater drive
- cool_on  out  1  cooler drive
- state  out  2  current state encoding
- fault  out  1  sticky run-length fault

Behaviour:
- Arithmetic:
  - diff = {1'b0,Tset} - {1'b0,Tact}, WIDTH+1 bits, signed.
  - too_cold = diff >= DEADBAND.
  - too_hot = -diff >= DEADBAND.
  - No unsigned wrap; too_cold and too_hot are mutually exclusive for DEADBAND >= 1.
- States: IDLE=2'b00, HEAT=2'b01, COOL=2'b10, LOCKOUT=2'b11. Moore machine.
  - heat_on = (state==HEAT), cool_on = (state==COOL); both driven from the state register, glitch-free.
- Reset (async assert, sync release):
  - state=IDLE, timer=0, heat_on=0, cool_on=0, fault=0.
  - Applies immediately, including mid-run.
- IDLE:
  - en && too_cold -> HEAT, timer <= MIN_ON-1.
  - en && too_hot -> COOL, timer <= MIN_ON-1.
  - Otherwise stay.
- HEAT:
  - Timer decrements to 0 and holds.
  - When timer==0 and (Tact >= Tset or !en) -> LOCKOUT, timer <= MIN_OFF-1.
- COOL:
  - Same timing as HEAT.
  - Exit condition is timer==0 and (Tact <= Tset or !en).
- LOCKOUT:
  - Outputs off; timer decrements.
  - timer==0 -> IDLE. Inputs are ignored.
- Latency:
  - Conditions are sampled at edge n; the output changes after edge n.
  - A run lasts at least MIN_ON cycles.
  - Lockout lasts exactly MIN_OFF cycles.
  - After lockout, at least 1 IDLE cycle precedes a new run.
- Deassertion of en:
  - Mid-run: honoured only once the MIN_ON timer has expired.
  - In LOCKOUT: no effect.
- No direct HEAT<->COOL transition; every run passes through LOCKOUT.
- Inputs are assumed synchronous to clk.

Optional Feature:
- Macro: THERMO_ALARM_EN.
- Defined:
  - A run counter clears on entry to HEAT/COOL and increments each run cycle.
  - When it reaches MAX_RUN: fault <= 1 (sticky) and next state = LOCKOUT.
  - While fault=1, IDLE never starts a run.
  - clr_fault=1 clears fault on the next edge.
  - rst_n also clears fault.
- Undefined:
  - The run counter is absent.
  - fault is tied 0 and clr_fault is ignored.
  - The port list is unchanged.

Decomposition:
- Package thermo_pkg:
  - State encodings IDLE/HEAT/COOL/LOCKOUT as a 2-bit typedef.
  - Default constants for DEADBAND, MIN_ON, MIN_OFF.
- Sub-module thermo_timer:
  - CNT_W loadable down-counter with load, load value, decrement and zero flag, saturating at 0.
  - Instantiated once for the run/lockout timer.
  - Instantiated a second time for the run counter under THERMO_ALARM_EN.

Test Plan:
1. Tset=25, Tact=21, en=1, released from reset -> heat_on=1 on the cycle after the first sampling edge; state=01.
2. During HEAT, Tact=25 at run cycle 3 -> heat_on held through cycle 16, then LOCKOUT for 8 cycles, then IDLE; cool_on=0 throughout.
3. Tset=25: Tact=24 -> no run; then Tact=29 -> COOL; then Tact=25 after timer expiry -> LOCKOUT.
4. Wrap-around check: Tset=2, Tact=250 -> COOL, never HEAT. Tset=250, Tact=2 -> HEAT.
5. In LOCKOUT, Tact=10 with Tset=25 -> outputs stay 0 until lockout ends, one IDLE cycle, then HEAT.
6. rst_n pulsed low mid-COOL -> cool_on=0 asynchronously, state=00.
7. With THERMO_ALARM_EN, MAX_RUN=64, Tact held at 10 -> fault=1 at run cycle 64 and LOCKOUT; no restart until clr_fault pulse.
